// File: rtl/rr_arb8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: state encoding,
// requester count and the index-to-one-hot helper.
package rr_arb8_pkg;

  localparam int NREQ = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Convert a 3-bit requester index into its one-hot grant vector.
  function automatic logic [NREQ-1:0] id_to_onehot(input logic [2:0] id);
    return 8'd1 << id;
  endfunction

endpackage

// File: rtl/rr_arb8_prio_enc8.sv
// 8-to-3 priority encoder: reports the index of the highest set input bit.
module prio_enc8 (
  input  logic [7:0] in,
  output logic [2:0] out,
  output logic       valid
);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    out   = 3'd0;
    valid = |in;
    for (int i = 0; i < 8; i++) begin
      out = in[i] ? 3'(i) : out;
    end
  end

endmodule

// File: rtl/rr_arb8.sv
// 8-requester round-robin arbiter with a bounded hold time per grant and a
// one-cycle gap between owners. All outputs come straight from flops.
module rr_arb8
  import rr_arb8_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            done,
  output logic [NREQ-1:0] gnt,
  output logic [2:0]      gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  state_t          state_r, state_s;
  logic [NREQ-1:0] gnt_r, gnt_s;
  logic [2:0]      gnt_id_r, gnt_id_s;
  logic            gnt_valid_r, gnt_valid_s;
  logic            timeout_r, timeout_s;
  logic [7:0]      hold_cnt_r, hold_cnt_s;
  logic [2:0]      last_id_r, last_id_s;

  logic [NREQ-1:0] mask_s;
  logic [NREQ-1:0] masked_s;
  logic [2:0]      masked_id_s;
  logic            masked_vld_s;
  logic [2:0]      any_id_s;
  logic            any_vld_s;
  logic [2:0]      winner_s;

  // Only requesters below the previous owner are eligible in the first pass;
  // last_id of zero empties the mask so bit 7 is favoured.
  always_comb begin
    mask_s   = (8'd1 << last_id_r) - 8'd1;
    masked_s = req & mask_s;
    winner_s = masked_vld_s ? masked_id_s : any_id_s;
  end

  prio_enc8 u_enc_masked (
    .in    (masked_s),
    .out   (masked_id_s),
    .valid (masked_vld_s)
  );

  prio_enc8 u_enc_any (
    .in    (req),
    .out   (any_id_s),
    .valid (any_vld_s)
  );

  // Next-state and next-output decode for the IDLE/GRANT/GAP controller.
  always_comb begin
    state_s    = state_r;
    gnt_s      = gnt_r;
    gnt_id_s   = gnt_id_r;
    hold_cnt_s = hold_cnt_r;
    last_id_s  = last_id_r;
    timeout_s  = 1'b0;
    case (state_r)
      IDLE, GAP: begin
        if (any_vld_s) begin
          state_s    = GRANT;
          gnt_s      = id_to_onehot(winner_s);
          gnt_id_s   = winner_s;
          hold_cnt_s = 8'd0;
        end else begin
          state_s = IDLE;
          gnt_s   = 8'h00;
        end
      end
      GRANT: begin
        if (done || !req[gnt_id_r]) begin
          state_s   = GAP;
          gnt_s     = 8'h00;
          last_id_s = gnt_id_r;
        end else if (hold_cnt_r == HOLD_LIM) begin
          state_s   = GAP;
          gnt_s     = 8'h00;
          last_id_s = gnt_id_r;
          timeout_s = 1'b1;
        end else begin
          hold_cnt_s = (hold_cnt_r == 8'hFF) ? hold_cnt_r : hold_cnt_r + 8'd1;
        end
      end
      default: begin
        state_s    = IDLE;
        gnt_s      = 8'h00;
        gnt_id_s   = 3'd0;
        hold_cnt_s = 8'd0;
      end
    endcase
    gnt_valid_s = (state_s == GRANT);
  end

  // State and output registers; reset drops the grant immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      gnt_r       <= 8'h00;
      gnt_id_r    <= 3'd0;
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
      hold_cnt_r  <= 8'd0;
      last_id_r   <= 3'd0;
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      gnt_id_r    <= gnt_id_s;
      gnt_valid_r <= gnt_valid_s;
      timeout_r   <= timeout_s;
      hold_cnt_r  <= hold_cnt_s;
      last_id_r   <= last_id_s;
    end
  end

  assign gnt       = gnt_r;
  assign gnt_id    = gnt_id_r;
  assign gnt_valid = gnt_valid_r;
  assign timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arb8.sv
// Directed scoreboard bench for rr_arb8: instance a uses MAX_HOLD=4,
// instance b uses MAX_HOLD=2 for the done/expiry collision case.
module tb_rr_arb8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_a, req_b;
  logic       done_a, done_b;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] id_a, id_b;
  logic       vld_a, vld_b;
  logic       to_a, to_b;

  int tests_run;
  int tests_failed;
  int step_no;

  // expected entry: {gnt[7:0], valid, timeout, id[2:0]}
  logic [12:0] exp_q[$];

  rr_arb8 #(.MAX_HOLD(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .done(done_a),
    .gnt(gnt_a), .gnt_id(id_a), .gnt_valid(vld_a), .timeout(to_a)
  );

  rr_arb8 #(.MAX_HOLD(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .done(done_b),
    .gnt(gnt_b), .gnt_id(id_b), .gnt_valid(vld_b), .timeout(to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] onehot_idx(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Drive one cycle of stimulus on the selected instance, queue the expected
  // outputs after the next edge, then compare.
  task automatic step(input logic sel, input logic [7:0] r, input logic d,
                      input logic [7:0] eg, input logic ev, input logic et);
    logic [12:0] e;
    logic [7:0]  og;
    logic [2:0]  oid;
    logic        ov, ot;
    req_a  = sel ? 8'h00 : r;
    done_a = sel ? 1'b0 : d;
    req_b  = sel ? r : 8'h00;
    done_b = sel ? d : 1'b0;
    exp_q.push_back({eg, ev, et, onehot_idx(eg)});
    @(posedge clk);
    #1;
    step_no++;
    e   = exp_q.pop_front();
    og  = sel ? gnt_b : gnt_a;
    oid = sel ? id_b  : id_a;
    ov  = sel ? vld_b : vld_a;
    ot  = sel ? to_b  : to_a;
    check($sformatf("s%0d gnt", step_no), 32'(og), 32'(e[12:5]));
    check($sformatf("s%0d valid", step_no), 32'(ov), 32'(e[4]));
    check($sformatf("s%0d timeout", step_no), 32'(ot), 32'(e[3]));
    if (e[4]) check($sformatf("s%0d gnt_id", step_no), 32'(oid), 32'(e[2:0]));
  endtask

  initial begin
    tests_run = 0; tests_failed = 0; step_no = 0;
    rst_n = 1'b0; req_a = 8'h00; req_b = 8'h00; done_a = 1'b0; done_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst gnt", 32'(gnt_a), 32'h0);
    check("rst gnt_id", 32'(id_a), 32'h0);
    check("rst valid", 32'(vld_a), 32'h0);
    check("rst timeout", 32'(to_a), 32'h0);
    rst_n = 1'b1;

    // basic grant, release, round-robin to the low requester
    step(1'b0, 8'h81, 1'b0, 8'h80, 1'b1, 1'b0);
    step(1'b0, 8'h81, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h81, 1'b0, 8'h01, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // full rotation 7..0 then back to 7, one gap between owners
    for (int i = 0; i < 9; i++) begin
      step(1'b0, 8'hFF, 1'b0, 8'd1 << ((15 - i) % 8), 1'b1, 1'b0);
      step(1'b0, 8'hFF, 1'b1, 8'h00, 1'b0, 1'b0);
    end
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // hold expiry with MAX_HOLD=4
    for (int i = 0; i < 4; i++) step(1'b0, 8'h04, 1'b0, 8'h04, 1'b1, 1'b0);
    step(1'b0, 8'h04, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h04, 1'b0, 8'h04, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // owner 5 keeps grant while req[6] toggles, then drops its request
    step(1'b0, 8'h24, 1'b0, 8'h20, 1'b1, 1'b0);
    step(1'b0, 8'h64, 1'b0, 8'h20, 1'b1, 1'b0);
    step(1'b0, 8'h24, 1'b0, 8'h20, 1'b1, 1'b0);
    step(1'b0, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h04, 1'b0, 8'h04, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    // asynchronous reset in the middle of a grant
    step(1'b0, 8'h10, 1'b0, 8'h10, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async rst gnt", 32'(gnt_a), 32'h0);
    check("async rst valid", 32'(vld_a), 32'h0);
    check("async rst timeout", 32'(to_a), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 8'h11, 1'b0, 8'h10, 1'b1, 1'b0);
    step(1'b0, 8'h11, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h11, 1'b0, 8'h01, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);

    // MAX_HOLD=2: done coinciding with expiry, then a real expiry
    step(1'b1, 8'h04, 1'b0, 8'h04, 1'b1, 1'b0);
    step(1'b1, 8'h04, 1'b0, 8'h04, 1'b1, 1'b0);
    step(1'b1, 8'h04, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'h04, 1'b0, 8'h04, 1'b1, 1'b0);
    step(1'b1, 8'h04, 1'b0, 8'h04, 1'b1, 1'b0);
    step(1'b1, 8'h04, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rr_arb8.md
RR_ARB8 -- requirements
Module: rr_arb8

Interface
REQ-001 The module SHALL have parameter MAX_HOLD, default 16, meaning the maximum number of consecutive cycles one grant may be held (legal range 2..255).
REQ-002 The module SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-003 The module SHALL have port rst_n, input, 1 bit, the reset; it is asynchronous and active-low.
REQ-004 The module SHALL have port req, input, 8 bits, the request lines; bit 7 has the highest base priority.
REQ-005 The module SHALL have port done, input, 1 bit, the release strobe from the current owner.
REQ-006 The module SHALL have port gnt, output, 8 bits, the one-hot grant (registered).
REQ-007 The module SHALL have port gnt_id, output, 3 bits, the binary index of the owner; it is valid only while gnt_valid=1.
REQ-008 The module SHALL have port gnt_valid, output, 1 bit, high while any grant is active.
REQ-009 The module SHALL have port timeout, output, 1 bit, a one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-010 The FSM SHALL have the states IDLE, GRANT and GAP; gnt_valid SHALL equal (state==GRANT).
REQ-011 Arbitration SHALL be combinational and evaluated in IDLE and GAP as follows.
- masked = req & ((1<<last_id)-1).
- If masked is nonzero, the winner SHALL be the highest set bit of masked.
- Otherwise the winner SHALL be the highest set bit of req.
REQ-012 IDLE/GAP -> GRANT SHALL occur when req!=0. At that edge the module SHALL load gnt with the winner one-hot, load gnt_id with the winner, and set hold_cnt=0.
- Latency: request sampled at edge N, gnt visible after edge N.
REQ-013 IDLE/GAP with req==0 SHALL go to IDLE, with gnt=0.
REQ-014 In GRANT, the module SHALL stay in GRANT and increment hold_cnt while req[gnt_id]=1, done=0 and hold_cnt<MAX_HOLD-1.
REQ-015 GRANT -> GAP SHALL occur on the first of the following, with the indicated actions.
- done=1: release.
- req[gnt_id]=0: release.
- hold_cnt==MAX_HOLD-1 with the owner still requesting and done=0: release and assert timeout for the GAP cycle.
- On every GRANT -> GAP transition: last_id<=gnt_id and gnt<=0.
REQ-016 GAP SHALL last exactly one cycle with gnt=0. Back-to-back ownership changes SHALL therefore be separated by one idle cycle.
REQ-017 If done and timeout expiry coincide, the release SHALL be treated as done and timeout SHALL stay 0.
REQ-018 Changes on req bits other than gnt_id SHALL NOT affect an active grant.
REQ-019 gnt SHALL always be one-hot or zero and SHALL match gnt_id whenever it is nonzero.
REQ-020 With continuous requests, every requester SHALL be granted within 8 grant periods (starvation-free).
REQ-021 hold_cnt SHALL be 8 bits wide, SHALL saturate and never wrap, and SHALL be compared only against MAX_HOLD-1.

Reset
REQ-022 While rst_n=0 the outputs and state SHALL be held at the following values.
- state=IDLE.
- gnt=8'h00, gnt_id=3'd0, gnt_valid=0, timeout=0.
- hold_cnt=0, last_id=3'd0, so the first arbitration after reset favors bit 7.
REQ-023 rst_n assertion mid-grant SHALL drop gnt asynchronously in the same cycle, with no GAP and no timeout pulse.
REQ-024 After rst_n deassertion, the first grant SHALL occur at the first clk edge with req!=0.

Structure
REQ-025 The shared package/header SHALL hold the state encodings (IDLE=2'd0, GRANT=2'd1, GAP=2'd2) and the constant NREQ=8.
REQ-026 The 8-to-3 highest-bit priority encode SHALL be a sub-module named prio_enc8 with ports in[7:0], out[2:0] and valid.
- It SHALL be instantiated twice, once for masked and once for unmasked.
REQ-027 All outputs SHALL be driven directly from flops; no combinational path SHALL exist from req or done to any output.

Verification
REQ-028 Reset, then req=8'h81 held -> gnt=8'h80 one cycle later; done pulse -> GAP with gnt=0 -> gnt=8'h01.
REQ-029 req=8'hFF held, done pulsed each grant -> gnt_id sequence 7,6,5,4,3,2,1,0,7 with one GAP cycle between each.
REQ-030 MAX_HOLD=4, req=8'h04 held, done=0 -> gnt=8'h04 for 4 cycles, then GAP with timeout=1 for 1 cycle, then gnt=8'h04 again.
REQ-031 Owner 5 drops req[5] while req[2]=1 -> GAP next cycle, then gnt=8'h04; toggling req[6] during the grant -> no change.
REQ-032 rst_n pulsed low while gnt=8'h10 -> gnt=0 and gnt_valid=0 immediately; after release with req=8'h11 -> gnt=8'h10, since last_id reset favors bit 7.
REQ-033 done=1 on the same cycle as hold expiry, with MAX_HOLD=2 -> GAP entered and timeout stays 0.
